// File: rtl/tlp_demux_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlp_demux_rx_pkg
//  Purpose  : Shared definitions for the transaction-layer receive demux.
//             Holds the virtual-channel count, the legal destination codes,
//             the drop counter width and the destination legality check.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package tlp_demux_rx_pkg;

    localparam int NUM_VC     = 4;
    localparam int VC_W       = 2;
    localparam int DROP_CNT_W = 8;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    typedef enum logic [VC_W-1:0] {
        VC0 = 2'd0,
        VC1 = 2'd1,
        VC2 = 2'd2,
        VC3 = 2'd3
    } vc_e;

    // A destination is legal only if it names one of the implemented VCs.
    // The caller zero-extends its destination field to 32 bits.
    function automatic logic dest_is_legal(input logic [31:0] dest);
        return (dest < 32'(NUM_VC));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlp_demux_rx_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync
//  Purpose  : Single-clock FIFO with registered read data and registered
//             status flags derived from the post-update occupancy.
//  Ports    : clk, reset_L (sync, active-low)
//             push, wr_data            - write side (ignored when full)
//             pop                      - read request (ignored when empty)
//             rd_data, rd_valid        - word popped on the last edge
//             empty, full, almost_full - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sync #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_occ;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_empty;
    logic              r_full;
    logic              r_af;

    logic              w_do_push;
    logic              w_do_pop;
    logic [AW:0]       w_occ_nxt;

    // Pushes and pops are qualified by the registered flags, so a full FIFO
    // refuses a push even when it is popped in the same cycle. The memory
    // write is also held off during reset so reset wins over a push.
    assign w_do_push = push && !r_full && reset_L;
    assign w_do_pop  = pop  && !r_empty;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_do_push, w_do_pop})
            2'b10:   w_occ_nxt = r_occ + (AW+1)'(1);
            2'b01:   w_occ_nxt = r_occ - (AW+1)'(1);
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_af       <= 1'b0;
        end else begin
            r_rd_valid <= w_do_pop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end
            r_occ   <= w_occ_nxt;
            r_empty <= (w_occ_nxt == '0);
            r_full  <= (w_occ_nxt == (AW+1)'(DEPTH));
            r_af    <= (w_occ_nxt >= (AW+1)'(AF_THRESH));
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_af;

endmodule
`default_nettype wire

// File: rtl/tlp_demux_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tlp_demux_rx
//  Purpose  : Receive side of the transaction-layer arbiter link. Steers one
//             (data, dest) beat per cycle into one of four per-VC FIFOs,
//             applies per-destination backpressure and counts beats that
//             carry an illegal destination.
//  Ports    : clk, reset_L (sync, active-low)
//             in_valid, in_data, in_dest, in_ready - input beat handshake
//             pop0..3                              - per-VC read requests
//             data_out0..3, valid_out0..3          - per-VC read data
//             empty0..3, full0..3, almost_full0..3 - per-VC status
//             drop_cnt                             - saturating drop count
//  Revision : 1.0  initial release
// ============================================================================
module tlp_demux_rx
    import tlp_demux_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEST_W    = 4,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DEST_W-1:0]     in_dest,
    output logic                  in_ready,
    input  logic                  pop0,
    input  logic                  pop1,
    input  logic                  pop2,
    input  logic                  pop3,
    output logic [DATA_W-1:0]     data_out0,
    output logic [DATA_W-1:0]     data_out1,
    output logic [DATA_W-1:0]     data_out2,
    output logic [DATA_W-1:0]     data_out3,
    output logic                  valid_out0,
    output logic                  valid_out1,
    output logic                  valid_out2,
    output logic                  valid_out3,
    output logic                  empty0,
    output logic                  empty1,
    output logic                  empty2,
    output logic                  empty3,
    output logic                  full0,
    output logic                  full1,
    output logic                  full2,
    output logic                  full3,
    output logic                  almost_full0,
    output logic                  almost_full1,
    output logic                  almost_full2,
    output logic                  almost_full3,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic                  w_legal;
    vc_e                   w_vc;
    logic [NUM_VC-1:0]     w_pop;
    logic [NUM_VC-1:0]     w_push;
    logic [NUM_VC-1:0]     w_valid;
    logic [NUM_VC-1:0]     w_empty;
    logic [NUM_VC-1:0]     w_full;
    logic [NUM_VC-1:0]     w_af;
    logic [DATA_W-1:0]     w_data [NUM_VC];
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign w_legal = dest_is_legal(32'(in_dest));
    assign w_vc    = vc_e'(in_dest[VC_W-1:0]);

    // Illegal beats are always swallowed; legal beats only stall on a full
    // target FIFO. Pops in the same cycle deliberately do not free a slot.
    assign in_ready = !w_legal || !w_full[w_vc];

    always_comb begin
        w_push = '0;
        if (in_valid && in_ready && w_legal) begin
            w_push[w_vc] = 1'b1;
        end
    end

    assign w_pop = {pop3, pop2, pop1, pop0};

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        fifo_sync #(
            .DATA_W    (DATA_W),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_fifo (
            .clk         (clk),
            .reset_L     (reset_L),
            .push        (w_push[g]),
            .wr_data     (in_data),
            .pop         (w_pop[g]),
            .rd_data     (w_data[g]),
            .rd_valid    (w_valid[g]),
            .empty       (w_empty[g]),
            .full        (w_full[g]),
            .almost_full (w_af[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_drop_cnt <= '0;
        end else if (in_valid && !w_legal && (r_drop_cnt != DROP_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;

    assign data_out0    = w_data[0];
    assign data_out1    = w_data[1];
    assign data_out2    = w_data[2];
    assign data_out3    = w_data[3];
    assign valid_out0   = w_valid[0];
    assign valid_out1   = w_valid[1];
    assign valid_out2   = w_valid[2];
    assign valid_out3   = w_valid[3];
    assign empty0       = w_empty[0];
    assign empty1       = w_empty[1];
    assign empty2       = w_empty[2];
    assign empty3       = w_empty[3];
    assign full0        = w_full[0];
    assign full1        = w_full[1];
    assign full2        = w_full[2];
    assign full3        = w_full[3];
    assign almost_full0 = w_af[0];
    assign almost_full1 = w_af[1];
    assign almost_full2 = w_af[2];
    assign almost_full3 = w_af[3];

endmodule
`default_nettype wire
